// File: rtl/mdu.sv
// rtl/mdu.sv - multiply/divide unit with HI/LO registers and fixed-latency busy window
module mdu #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       mdop,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC) + 1;

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t           r_state;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [CW-1:0]    r_cnt;

    logic signed [2*WIDTH-1:0] w_sprod;
    logic        [2*WIDTH-1:0] w_uprod;
    logic        [WIDTH-1:0]   w_bs;
    logic signed [WIDTH-1:0]   w_sq;
    logic signed [WIDTH-1:0]   w_sr;
    logic        [WIDTH-1:0]   w_uq;
    logic        [WIDTH-1:0]   w_ur;
    logic                      w_ovf;
    logic        [WIDTH-1:0]   w_res_hi;
    logic        [WIDTH-1:0]   w_res_lo;
    logic                      w_res_wr;
    logic                      w_accept;

    assign w_sprod = $signed({{WIDTH{r_a[WIDTH-1]}}, r_a}) * $signed({{WIDTH{r_b[WIDTH-1]}}, r_b});
    assign w_uprod = {{WIDTH{1'b0}}, r_a} * {{WIDTH{1'b0}}, r_b};

    // Divisor forced to 1 when zero so the dividers never see x; the write is suppressed anyway.
    assign w_bs  = (r_b == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : r_b;
    assign w_sq  = $signed(r_a) / $signed(w_bs);
    assign w_sr  = $signed(r_a) % $signed(w_bs);
    assign w_uq  = r_a / w_bs;
    assign w_ur  = r_a % w_bs;
    assign w_ovf = (r_a == {1'b1, {(WIDTH-1){1'b0}}}) && (r_b == '1);

    always_comb begin
        w_res_hi = r_hi;
        w_res_lo = r_lo;
        w_res_wr = 1'b0;
        case (r_op)
            OP_MULT: begin
                w_res_hi = w_sprod[2*WIDTH-1:WIDTH];
                w_res_lo = w_sprod[WIDTH-1:0];
                w_res_wr = 1'b1;
            end
            OP_MULTU: begin
                w_res_hi = w_uprod[2*WIDTH-1:WIDTH];
                w_res_lo = w_uprod[WIDTH-1:0];
                w_res_wr = 1'b1;
            end
            OP_DIV: begin
                if (w_ovf) begin
                    w_res_hi = '0;
                    w_res_lo = r_a;
                end else begin
                    w_res_hi = w_sr;
                    w_res_lo = w_sq;
                end
                w_res_wr = (r_b != '0);
            end
            OP_DIVU: begin
                w_res_hi = w_ur;
                w_res_lo = w_uq;
                w_res_wr = (r_b != '0);
            end
            default: ;
        endcase
    end

    assign w_accept = start && (r_state == S_IDLE) && (mdop >= OP_MULT) && (mdop <= OP_DIVU);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_cnt   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_BUSY;
                        r_busy  <= 1'b1;
                        r_a     <= A;
                        r_b     <= B;
                        r_op    <= mdop;
                        r_cnt   <= (mdop <= OP_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
                    end else if (start && mdop == OP_MTHI) begin
                        r_hi <= A;
                    end else if (start && mdop == OP_MTLO) begin
                        r_lo <= A;
                    end
                end
                S_BUSY: begin
                    // Counter holds the busy cycles remaining, including the current one.
                    if (r_cnt == CW'(1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cnt   <= '0;
                        if (w_res_wr) begin
                            r_hi <= w_res_hi;
                            r_lo <= w_res_lo;
                        end
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// tb/tb_mdu.sv - scoreboard-driven directed bench for the multiply/divide unit
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  mdop;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_assert = 0;
    int n_fail   = 0;

    logic [63:0] sb[$];
    logic [31:0] m_hi = 32'h0;
    logic [31:0] m_lo = 32'h0;

    mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .mdop  (mdop),
        .A     (A),
        .B     (B),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] h,
                                          input logic [31:0] l);
        longint          sp;
        longint unsigned up;
        int              q;
        int              r;
        model = {h, l};
        case (op)
            3'd1: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                model = sp;
            end
            3'd2: begin
                up = longint'({32'h0, a}) * longint'({32'h0, b});
                model = up;
            end
            3'd3: begin
                if (b == 32'h0) model = {h, l};
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
                else begin
                    q = $signed(a) / $signed(b);
                    r = $signed(a) - q * $signed(b);
                    model = {r, q};
                end
            end
            3'd4: begin
                if (b != 32'h0) model = {a % b, a / b};
            end
            default: ;
        endcase
    endfunction

    // Launch one multiply/divide, optionally poke an MTLO on busy cycle `inj`, check timing and result.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int inj);
        int          n;
        int          expn;
        logic [63:0] e;
        e = model(op, a, b, m_hi, m_lo);
        sb.push_back(e);
        m_hi = e[63:32];
        m_lo = e[31:0];
        expn = (op <= 3'd2) ? 5 : 10;
        start = 1'b1; mdop = op; A = a; B = b;
        tick();
        chk({tag, "_busy_on"}, {63'h0, busy}, 64'h1);
        chk({tag, "_done_lo"}, {63'h0, done}, 64'h0);
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            n++;
            if (n == inj) begin
                start = 1'b1; mdop = 3'd6; A = 32'h0000_DEAD; B = 32'h0;
            end else begin
                start = 1'b0; A = $urandom; B = $urandom;
            end
            tick();
        end
        start = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(n), 64'(expn));
        chk({tag, "_done"}, {63'h0, done}, 64'h1);
        if (sb.size() > 0) chk({tag, "_hilo"}, {hi, lo}, sb.pop_front());
        else chk({tag, "_sb_empty"}, 64'(sb.size()), 64'h1);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1; start = 1'b1; mdop = 3'd1; A = 32'h5; B = 32'h7;
        tick();
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_hilo", {hi, lo}, 64'h0);
        reset = 1'b0; start = 1'b0; mdop = 3'd0;
        tick();
        chk("rst_no_accept", {63'h0, busy}, 64'h0);

        do_op("mult", 3'd1, 32'hFFFF_FFFF, 32'h2, 0);
        chk("mult_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFE);
        tick();
        chk("mult_done_pulse", {63'h0, done}, 64'h0);

        do_op("multu", 3'd2, 32'hFFFF_FFFF, 32'h2, 0);
        chk("multu_const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);

        do_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'h2, 0);
        chk("div_neg_const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        do_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("div_ovf_const", {hi, lo}, 64'h0000_0000_8000_0000);

        start = 1'b1; mdop = 3'd5; A = 32'h1234_5678;
        tick();
        start = 1'b0;
        m_hi = 32'h1234_5678;
        chk("mthi", {hi, lo}, {32'h1234_5678, 32'h8000_0000});
        chk("mthi_busy_done", {62'h0, busy, done}, 64'h0);
        do_op("divu_zero", 3'd4, 32'h7, 32'h0, 0);
        chk("divu_zero_const", {hi, lo}, {32'h1234_5678, 32'h8000_0000});

        tick();
        do_op("divu_inj", 3'd4, 32'd100, 32'd7, 3);
        chk("divu_inj_const", {hi, lo}, {32'd2, 32'd14});

        start = 1'b1; mdop = 3'd0; A = 32'hAAAA_AAAA;
        tick();
        mdop = 3'd7;
        tick();
        start = 1'b0; mdop = 3'd6;
        tick();
        chk("nop_ops", {hi, lo}, {32'd2, 32'd14});
        chk("nop_busy", {63'h0, busy}, 64'h0);

        for (int i = 0; i < 8; i++) begin
            rop = 3'(1 + (i % 4));
            ra  = $urandom;
            rb  = (i == 6) ? 32'h0 : ((i % 3 == 0) ? 32'($urandom_range(1, 50)) : $urandom);
            do_op($sformatf("rnd%0d", i), rop, ra, rb, 0);
        end

        do_op_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    task automatic do_op_reset();
        int seen;
        start = 1'b1; mdop = 3'd1; A = 32'h0000_0003; B = 32'h0000_0004;
        tick();
        start = 1'b0;
        chk("abort_busy1", {63'h0, busy}, 64'h1);
        tick();
        chk("abort_busy2", {63'h0, busy}, 64'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy_off", {63'h0, busy}, 64'h0);
        chk("abort_hilo", {hi, lo}, 64'h0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (done !== 1'b0 || busy !== 1'b0) seen++;
        end
        chk("abort_no_done", 64'(seen), 64'h0);
        chk("abort_hilo_after", {hi, lo}, 64'h0);
    endtask

endmodule
